ov7670_capture_ctrl: RTL and testbench

- Parametrised successor to the OV7670 capture front end.
- Converts the camera byte stream (href/v_sync/8-bit data, pclk domain) into frame-buffer write transactions.
- Adds configurable source resolution, integer decimation, RGB444/RGB565 output format, and frame-synchronous enable.
- Adds frame/line status pulses.
- Sits between the camera pins and the dual-port frame buffer write port.

---
 rtl/ov7670_capture_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ov7670_capture_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture_ctrl.sv
// OV7670 capture front end: turns the camera href/v_sync byte stream into
// decimated, formatted frame-buffer writes with frame and line status pulses.
module ov7670_capture_ctrl #(
    parameter int unsigned SRC_W   = 640,
    parameter int unsigned SRC_H   = 480,
    parameter int unsigned DEC     = 2,
    parameter int unsigned OUT_FMT = 0,
    parameter int unsigned ADDR_W  = 17
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              enable,
    input  logic              href,
    input  logic              v_sync,
    input  logic [7:0]        ov7670_data,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [15:0]       wData,
    output logic              frame_start,
    output logic              frame_done,
    output logic              line_err,
    output logic              busy
);

    localparam int unsigned LINE_BYTES = 2 * SRC_W;
    localparam int unsigned BC_W       = $clog2(LINE_BYTES + 2) + 1;
    localparam int unsigned PX_W       = BC_W - 1;
    localparam int unsigned LY_W       = $clog2(SRC_H + 1) + 1;
    localparam int unsigned DEC_M      = DEC - 1;
    localparam int unsigned MAX_ADDR   = (SRC_W / DEC) * (SRC_H / DEC) - 1;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_WAIT_FRAME,
        ST_CAPTURE
    } state_t;

    state_t            state_q, state_d;
    logic              vs_d_q, hr_d_q;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [LY_W-1:0]   line_y_q, line_y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              full_q, full_d;
    logic [7:0]        b0_q, b0_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_done_q, frame_done_d;
    logic              line_err_q, line_err_d;
    logic              busy_q, busy_d;

    logic              vs_fall, vs_rise, hr_fall;
    logic [PX_W-1:0]   pix_x;
    logic              keep;
    logic [15:0]       pix_fmt;

    assign vs_fall = vs_d_q & ~v_sync;
    assign vs_rise = ~vs_d_q & v_sync;
    assign hr_fall = hr_d_q & ~href;

    // Pixel completes on the odd byte; keep only on-grid, in-window pixels.
    assign pix_x = PX_W'(byte_cnt_q >> 1);
    assign keep  = byte_cnt_q[0]
                 && ((pix_x & PX_W'(DEC_M)) == '0)
                 && ((line_y_q & LY_W'(DEC_M)) == '0)
                 && (pix_x < PX_W'(SRC_W))
                 && (line_y_q < LY_W'(SRC_H))
                 && !full_q;

    assign pix_fmt = (OUT_FMT == 1) ? {b0_q, ov7670_data}
                   : {4'h0, b0_q[7:4], b0_q[2:0], ov7670_data[7], ov7670_data[4:1]};

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        line_y_d      = line_y_q;
        addr_d        = addr_q;
        full_d        = full_q;
        b0_d          = b0_q;
        we_d          = 1'b0;
        waddr_d       = waddr_q;
        wdata_d       = wdata_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        line_err_d    = 1'b0;

        case (state_q)
            ST_SYNC: begin
                if (v_sync) state_d = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
                if (vs_fall && enable) begin
                    state_d       = ST_CAPTURE;
                    frame_start_d = 1'b1;
                    line_y_d      = '0;
                    addr_d        = '0;
                    full_d        = 1'b0;
                    byte_cnt_d    = '0;
                end
            end
            ST_CAPTURE: begin
                if (href) begin
                    if (!byte_cnt_q[0]) begin
                        b0_d = ov7670_data;
                    end else if (keep) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = pix_fmt;
                        if (addr_q == ADDR_W'(MAX_ADDR)) full_d = 1'b1;
                        else                             addr_d = addr_q + 1'b1;
                    end
                    // Saturate so a runaway line cannot wrap back onto the grid.
                    if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 1'b1;
                end
                if (hr_fall) begin
                    line_err_d = (byte_cnt_q != BC_W'(LINE_BYTES));
                    byte_cnt_d = '0;
                    if (line_y_q != '1) line_y_d = line_y_q + 1'b1;
                end
                if (vs_rise) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_WAIT_FRAME;
                end
            end
            default: state_d = ST_SYNC;
        endcase

        busy_d = (state_d == ST_CAPTURE);
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q       <= ST_SYNC;
            vs_d_q        <= 1'b0;
            hr_d_q        <= 1'b0;
            byte_cnt_q    <= '0;
            line_y_q      <= '0;
            addr_q        <= '0;
            full_q        <= 1'b0;
            b0_q          <= '0;
            we_q          <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            line_err_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_d_q        <= v_sync;
            hr_d_q        <= href;
            byte_cnt_q    <= byte_cnt_d;
            line_y_q      <= line_y_d;
            addr_q        <= addr_d;
            full_q        <= full_d;
            b0_q          <= b0_d;
            we_q          <= we_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            line_err_q    <= line_err_d;
            busy_q        <= busy_d;
        end
    end

    assign we          = we_q;
    assign wAddr       = waddr_q;
    assign wData       = wdata_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign line_err    = line_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Bench: two capture instances (DEC=1/RGB565 and DEC=2/RGB444) share one
// randomized camera stream; writes are compared against a frame-level model.
module tb_ov7670_capture_ctrl;

    localparam int SW = 8;
    localparam int SH = 4;

    logic        pclk = 1'b0;
    logic        reset, enable, href, v_sync;
    logic [7:0]  ov_data;

    logic        a_we, a_fs, a_fd, a_le, a_busy;
    logic [4:0]  a_waddr;
    logic [15:0] a_wdata;
    logic        b_we, b_fs, b_fd, b_le, b_busy;
    logic [2:0]  b_waddr;
    logic [15:0] b_wdata;

    always #5 pclk = ~pclk;

    ov7670_capture_ctrl #(.SRC_W(SW), .SRC_H(SH), .DEC(1), .OUT_FMT(1), .ADDR_W(5)) dut_a (
        .pclk(pclk), .reset(reset), .enable(enable), .href(href), .v_sync(v_sync),
        .ov7670_data(ov_data), .we(a_we), .wAddr(a_waddr), .wData(a_wdata),
        .frame_start(a_fs), .frame_done(a_fd), .line_err(a_le), .busy(a_busy));

    ov7670_capture_ctrl #(.SRC_W(SW), .SRC_H(SH), .DEC(2), .OUT_FMT(0), .ADDR_W(3)) dut_b (
        .pclk(pclk), .reset(reset), .enable(enable), .href(href), .v_sync(v_sync),
        .ov7670_data(ov_data), .we(b_we), .wAddr(b_waddr), .wData(b_wdata),
        .frame_start(b_fs), .frame_done(b_fd), .line_err(b_le), .busy(b_busy));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: log every write and pulse of both instances.
    logic [31:0] a_q[$], b_q[$];
    int a_nfs = 0, a_nfd = 0, a_nle = 0, b_nfs = 0, b_nfd = 0, b_nle = 0;
    always @(negedge pclk) begin
        if (a_we) a_q.push_back({16'(a_waddr), a_wdata});
        if (b_we) b_q.push_back({16'(b_waddr), b_wdata});
        a_nfs <= a_nfs + int'(a_fs);
        a_nfd <= a_nfd + int'(a_fd);
        a_nle <= a_nle + int'(a_le);
        b_nfs <= b_nfs + int'(b_fs);
        b_nfd <= b_nfd + int'(b_fd);
        b_nle <= b_nle + int'(b_le);
    end

    logic [7:0] fbytes [0:5][0:19];
    int nlen [0:5];
    int nlines;
    int a_base, b_base, a_fs0, a_fd0, a_le0, b_fs0, b_fd0, b_le0;
    logic [31:0] exp_q[$];
    int len_tab [0:8] = '{16, 16, 16, 16, 15, 14, 17, 18, 2};

    task automatic gen_frame(input int nl, input bit rnd_len);
        nlines = nl;
        for (int y = 0; y < 6; y++) begin
            nlen[y] = rnd_len ? len_tab[$urandom_range(0, 8)] : 2 * SW;
            for (int i = 0; i < 20; i++) fbytes[y][i] = 8'($urandom);
        end
    endtask

    // Reference: walk the frame pixel by pixel, apply the keep rule, count addresses.
    task automatic build_exp(input int dec, input int fmt, input int maxa, input bit en);
        int addr;
        int b0, b1, d;
        exp_q.delete();
        addr = 0;
        if (en) begin
            for (int y = 0; y < nlines; y++) begin
                for (int x = 0; x < nlen[y] / 2; x++) begin
                    b0 = int'(fbytes[y][2*x]);
                    b1 = int'(fbytes[y][2*x+1]);
                    if (x % dec == 0 && y % dec == 0 && x < SW && y < SH && addr <= maxa) begin
                        if (fmt == 1) d = b0 * 256 + b1;
                        else d = (b0 / 16) * 256 + (b0 % 8) * 32 + (b1 / 128) * 16 + (b1 / 2) % 16;
                        exp_q.push_back(32'(addr * 65536 + d));
                        addr++;
                    end
                end
            end
        end
    endtask

    task automatic cmp_writes(input string tag, input bit use_b, input int base);
        int n;
        logic [31:0] got;
        n = use_b ? b_q.size() - base : a_q.size() - base;
        chk($sformatf("%s_nwr", tag), 32'(n), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < n; k++) begin
            got = use_b ? b_q[base + k] : a_q[base + k];
            chk($sformatf("%s_wr%0d", tag, k), got, exp_q[k]);
        end
    endtask

    task automatic run_frame(input bit en, input bit drop_mid, input bit sim_end, input bit timing);
        int le_exp;
        @(negedge pclk);
        v_sync = 1'b1; href = 1'b0; enable = en;
        repeat (4) @(negedge pclk);
        a_base = a_q.size(); b_base = b_q.size();
        a_fs0 = a_nfs; a_fd0 = a_nfd; a_le0 = a_nle;
        b_fs0 = b_nfs; b_fd0 = b_nfd; b_le0 = b_nle;
        v_sync = 1'b0;
        repeat (3) @(negedge pclk);
        for (int y = 0; y < nlines; y++) begin
            if (drop_mid && y == 1) enable = 1'b0;
            for (int i = 0; i < nlen[y]; i++) begin
                href = 1'b1; ov_data = fbytes[y][i];
                @(negedge pclk);
                if (timing && y == 0 && i < 2) begin
                    chk($sformatf("a_we_lat%0d", i), 32'(a_we), 32'(i == 1));
                    chk($sformatf("b_we_lat%0d", i), 32'(b_we), 32'(i == 1));
                    if (i == 0) chk("a_busy", 32'(a_busy), 32'(1));
                end
            end
            href = 1'b0;
            if (sim_end && y == nlines - 1) v_sync = 1'b1;
            repeat (3) @(negedge pclk);
        end
        v_sync = 1'b1;
        repeat (4) @(negedge pclk);

        le_exp = 0;
        for (int y = 0; y < nlines; y++) if (nlen[y] != 2 * SW) le_exp++;
        chk("a_fs", 32'(a_nfs - a_fs0), 32'(en));
        chk("a_fd", 32'(a_nfd - a_fd0), 32'(en));
        chk("a_le", 32'(a_nle - a_le0), en ? 32'(le_exp) : 32'(0));
        chk("b_fs", 32'(b_nfs - b_fs0), 32'(en));
        chk("b_fd", 32'(b_nfd - b_fd0), 32'(en));
        chk("b_le", 32'(b_nle - b_le0), en ? 32'(le_exp) : 32'(0));
        chk("a_busy_end", 32'(a_busy), 32'(0));
        build_exp(1, 1, SW * SH - 1, en);
        cmp_writes("a", 1'b0, a_base);
        build_exp(2, 0, (SW / 2) * (SH / 2) - 1, en);
        cmp_writes("b", 1'b1, b_base);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; enable = 1'b1; href = 1'b0; v_sync = 1'b0; ov_data = 8'h00;
        repeat (3) @(negedge pclk);
        chk("rst_we", 32'(a_we), 32'(0));
        chk("rst_waddr", 32'(a_waddr), 32'(0));
        chk("rst_wdata", 32'(a_wdata), 32'(0));
        chk("rst_pulses", {29'(0), a_fs, a_fd, a_le}, 32'(0));
        chk("rst_busy", 32'(a_busy), 32'(0));

        // Active bytes with no v_sync cycle since reset must not be captured.
        reset = 1'b0;
        a_base = a_q.size(); b_base = b_q.size(); a_fs0 = a_nfs;
        for (int i = 0; i < 24; i++) begin
            href = (i % 12) < 10; ov_data = 8'($urandom);
            @(negedge pclk);
        end
        href = 1'b0;
        @(negedge pclk);
        chk("sync_a_nwr", 32'(a_q.size() - a_base), 32'(0));
        chk("sync_b_nwr", 32'(b_q.size() - b_base), 32'(0));
        chk("sync_fs", 32'(a_nfs - a_fs0), 32'(0));
        chk("sync_busy", 32'(a_busy), 32'(0));

        // Full frame, known leading pixel, latency check.
        gen_frame(4, 1'b0);
        fbytes[0][0] = 8'hAB; fbytes[0][1] = 8'hCD;
        run_frame(1'b1, 1'b0, 1'b0, 1'b1);
        chk("a_first", (a_q.size() > a_base) ? a_q[a_base] : 32'hDEAD, 32'h0000ABCD);
        chk("a_last_addr", 32'(a_q[a_q.size() - 1] >> 16), 32'(31));

        // Short line: line_err, trailing byte dropped, addresses continue.
        gen_frame(4, 1'b0);
        nlen[1] = 15;
        fbytes[0][0] = 8'hF5; fbytes[0][1] = 8'hAA;
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        chk("b_fmt0", (b_q.size() > b_base) ? b_q[b_base] : 32'hDEAD, 32'h00000FB5);

        gen_frame(4, 1'b1);
        run_frame(1'b0, 1'b0, 1'b0, 1'b0);
        gen_frame(4, 1'b1);
        run_frame(1'b1, 1'b1, 1'b0, 1'b0);
        gen_frame(4, 1'b0);
        nlen[3] = 13;
        run_frame(1'b1, 1'b0, 1'b1, 1'b0);

        for (int f = 0; f < 10; f++) begin
            gen_frame($urandom_range(3, 5), 1'b1);
            run_frame($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, 1'b0);
        end

        // Reset in the middle of a frame.
        gen_frame(4, 1'b0);
        v_sync = 1'b1; enable = 1'b1;
        repeat (3) @(negedge pclk);
        v_sync = 1'b0;
        repeat (3) @(negedge pclk);
        for (int i = 0; i < 7; i++) begin
            href = 1'b1; ov_data = 8'($urandom);
            @(negedge pclk);
        end
        reset = 1'b1;
        @(negedge pclk);
        chk("mrst_we", 32'(a_we), 32'(0));
        chk("mrst_busy", 32'(a_busy), 32'(0));
        chk("mrst_waddr", 32'(a_waddr), 32'(0));
        chk("mrst_wdata", 32'(b_wdata), 32'(0));
        reset = 1'b0; href = 1'b0;
        a_base = a_q.size();
        for (int i = 0; i < 10; i++) begin
            href = 1'b1; ov_data = 8'($urandom);
            @(negedge pclk);
        end
        href = 1'b0;
        @(negedge pclk);
        chk("mrst_nwr", 32'(a_q.size() - a_base), 32'(0));
        gen_frame(4, 1'b1);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
